// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master controller: FSM state encoding,
// slave index type and the address-MSB slave decode helper.
package apb_pkg;

   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      SETUP  = ST_SETUP,
      ACCESS = ST_ACCESS
   } apb_state_e;

   typedef enum logic {
      SLV1 = 1'b0,
      SLV2 = 1'b1
   } slave_idx_e;

   function automatic slave_idx_e decode_slave(input logic addr_msb);
      return addr_msb ? SLV2 : SLV1;
   endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Slave select decode and return-path multiplexer for the two APB slaves.
// Only the addressed slave's PRDATA/PREADY/PSLVERR reach the controller.
module apb_slave_mux
   import apb_pkg::*;
#(
   parameter int DATA_W = APB_DATA_W
) (
   input  logic              active,
   input  slave_idx_e        slave,
   output logic              psel1,
   output logic              psel2,
   input  logic [DATA_W-1:0] prdata1,
   input  logic [DATA_W-1:0] prdata2,
   input  logic              pready1,
   input  logic              pready2,
   input  logic              pslverr1,
   input  logic              pslverr2,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);

   assign psel1 = active && (slave == SLV1);
   assign psel2 = active && (slave == SLV2);

   assign prdata  = (slave == SLV2) ? prdata2  : prdata1;
   assign pready  = (slave == SLV2) ? pready2  : pready1;
   assign pslverr = (slave == SLV2) ? pslverr2 : pslverr1;

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: sequences single read/write requests into SETUP/ACCESS phases
// for two slaves. Optional ACCESS wait timeout when APB_TIMEOUT_EN is defined.
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              transfer,
   input  logic              read_write,
   input  logic [ADDR_W-1:0] apb_write_paddr,
   input  logic [DATA_W-1:0] apb_write_data,
   input  logic [ADDR_W-1:0] apb_read_paddr,
   output logic [DATA_W-1:0] apb_read_data_out,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              PSEL1,
   output logic              PSEL2,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA1,
   input  logic [DATA_W-1:0] PRDATA2,
   input  logic              PREADY1,
   input  logic              PREADY2,
   input  logic              PSLVERR1,
   input  logic              PSLVERR2
);

   apb_state_e        state_reg, state_next;
   logic [ADDR_W-1:0] paddr_reg;
   logic [DATA_W-1:0] pwdata_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              pwrite_reg;
   logic              done_reg;
   logic              error_reg;

   logic [DATA_W-1:0] prdata_mux;
   logic              pready_mux;
   logic              pslverr_mux;
   logic              complete;
   logic              timeout_hit;
   logic              load_req;

   apb_slave_mux #(
      .DATA_W (DATA_W)
   ) u_slave_mux (
      .active   (state_reg != IDLE),
      .slave    (decode_slave(paddr_reg[ADDR_W-1])),
      .psel1    (PSEL1),
      .psel2    (PSEL2),
      .prdata1  (PRDATA1),
      .prdata2  (PRDATA2),
      .pready1  (PREADY1),
      .pready2  (PREADY2),
      .pslverr1 (PSLVERR1),
      .pslverr2 (PSLVERR2),
      .prdata   (prdata_mux),
      .pready   (pready_mux),
      .pslverr  (pslverr_mux)
   );

   assign complete = (state_reg == ACCESS) && pready_mux;
   // A new request is taken either from IDLE or on the completion edge (no gap).
   assign load_req = transfer && ((state_reg == IDLE) || complete);

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt_reg;

   // Abort on the wait cycle that would bring the count up to TIMEOUT_CYCLES.
   assign timeout_hit = (state_reg == ACCESS) && !pready_mux &&
                        (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wait_cnt_reg <= '0;
      end else if (state_reg == SETUP) begin
         wait_cnt_reg <= '0;
      end else if ((state_reg == ACCESS) && !pready_mux) begin
         wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      end
   end
`else
   // No timeout: ACCESS waits for PREADY indefinitely; expression is constant 0.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (transfer) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS: begin
            if (timeout_hit)     state_next = IDLE;
            else if (pready_mux) state_next = transfer ? SETUP : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_reg  <= IDLE;
         paddr_reg  <= '0;
         pwdata_reg <= '0;
         pwrite_reg <= 1'b0;
         rdata_reg  <= '0;
         done_reg   <= 1'b0;
         error_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= complete || timeout_hit;
         error_reg <= (complete && pslverr_mux) || timeout_hit;
         if (load_req) begin
            pwrite_reg <= !read_write;
            paddr_reg  <= read_write ? apb_read_paddr : apb_write_paddr;
            pwdata_reg <= apb_write_data;
         end
         // Read data is captured even when the slave flags an error.
         if (complete && !pwrite_reg) begin
            rdata_reg <= prdata_mux;
         end
      end
   end

   assign busy              = (state_reg != IDLE);
   assign PENABLE           = (state_reg == ACCESS);
   assign PADDR             = paddr_reg;
   assign PWDATA            = pwdata_reg;
   assign PWRITE            = pwrite_reg;
   assign done              = done_reg;
   assign error             = error_reg;
   assign apb_read_data_out = rdata_reg;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: vector table plus random transfers,
// reset-in-ACCESS sequence and (with APB_TIMEOUT_EN) the wait timeout abort.
module tb_apb_master_ctrl;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       transfer = 1'b0;
   logic       read_write = 1'b0;
   logic [7:0] apb_write_paddr = '0;
   logic [7:0] apb_write_data = '0;
   logic [7:0] apb_read_paddr = '0;
   logic [7:0] apb_read_data_out;
   logic       busy, done, error;
   logic       PSEL1, PSEL2, PENABLE, PWRITE;
   logic [7:0] PADDR, PWDATA;
   logic [7:0] PRDATA1 = '0, PRDATA2 = '0;
   logic       PREADY1 = 1'b0, PREADY2 = 1'b0;
   logic       PSLVERR1 = 1'b0, PSLVERR2 = 1'b0;

   apb_master_ctrl dut (
      .PCLK              (PCLK),
      .PRESETn           (PRESETn),
      .transfer          (transfer),
      .read_write        (read_write),
      .apb_write_paddr   (apb_write_paddr),
      .apb_write_data    (apb_write_data),
      .apb_read_paddr    (apb_read_paddr),
      .apb_read_data_out (apb_read_data_out),
      .busy              (busy),
      .done              (done),
      .error             (error),
      .PSEL1             (PSEL1),
      .PSEL2             (PSEL2),
      .PENABLE           (PENABLE),
      .PWRITE            (PWRITE),
      .PADDR             (PADDR),
      .PWDATA            (PWDATA),
      .PRDATA1           (PRDATA1),
      .PRDATA2           (PRDATA2),
      .PREADY1           (PREADY1),
      .PREADY2           (PREADY2),
      .PSLVERR1          (PSLVERR1),
      .PSLVERR2          (PSLVERR2)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      bit         rw;       // 1 = read
      logic [7:0] addr;
      logic [7:0] wdata;
      int         waits;    // PREADY-low ACCESS cycles
      bit         slverr;
      logic [7:0] rdata;
      bit         b2b;      // next request presented at the completion edge
      logic [1:0] exp_sel;  // {PSEL2, PSEL1}
      bit         exp_err;
   } vec_t;

   vec_t       vecs[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_rd = '0;
   bit         pend_done = 1'b0;
   bit         pend_err = 1'b0;

   function automatic vec_t mk(input bit rw, input logic [7:0] addr, input logic [7:0] wdata,
                               input int waits, input bit slverr, input logic [7:0] rdata,
                               input bit b2b, input logic [1:0] exp_sel, input bit exp_err);
      vec_t v;
      v.rw = rw; v.addr = addr; v.wdata = wdata; v.waits = waits; v.slverr = slverr;
      v.rdata = rdata; v.b2b = b2b; v.exp_sel = exp_sel; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic present(input vec_t v);
      transfer        = 1'b1;
      read_write      = v.rw;
      apb_write_paddr = v.rw ? 8'($urandom) : v.addr;
      apb_read_paddr  = v.rw ? v.addr : 8'($urandom);
      apb_write_data  = v.wdata;
   endtask

   // Unselected slave always gets random noise that must be ignored.
   task automatic drive_slaves(input int sel, input bit rdy, input bit err, input logic [7:0] rd);
      PREADY1 = 1'($urandom);  PREADY2 = 1'($urandom);
      PSLVERR1 = 1'($urandom); PSLVERR2 = 1'($urandom);
      PRDATA1 = 8'($urandom);  PRDATA2 = 8'($urandom);
      if (sel == 1) begin
         PREADY1 = rdy; PSLVERR1 = err; PRDATA1 = rd;
      end else if (sel == 2) begin
         PREADY2 = rdy; PSLVERR2 = err; PRDATA2 = rd;
      end
   endtask

   task automatic chk_common();
      chk("done", done, pend_done);
      if (pend_done) chk("error", error, pend_err);
      chk("read_data_out", apb_read_data_out, exp_rd);
      pend_done = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_psel"}, {PSEL2, PSEL1}, 2'b00);
      chk({tag, "_penable"}, PENABLE, 1'b0);
      chk({tag, "_pwrite"}, PWRITE, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
      chk({tag, "_paddr"}, PADDR, 8'h00);
      chk({tag, "_pwdata"}, PWDATA, 8'h00);
      chk({tag, "_rdata"}, apb_read_data_out, 8'h00);
   endtask

   // Lockstep run of vecs; every cycle is checked at the falling edge.
   task automatic run_seq();
      int n;
      n = vecs.size();
      @(negedge PCLK);
      chk_common();
      drive_slaves(0, 1'b0, 1'b0, 8'h00);
      present(vecs[0]);
      for (int i = 0; i < n; i++) begin
         vec_t v;
         int   sel;
         v   = vecs[i];
         sel = (v.exp_sel == 2'b10) ? 2 : 1;
         @(negedge PCLK);
         chk_common();
         chk("setup_psel", {PSEL2, PSEL1}, v.exp_sel);
         chk("setup_penable", PENABLE, 1'b0);
         chk("setup_busy", busy, 1'b1);
         chk("setup_paddr", PADDR, v.addr);
         chk("setup_pwrite", PWRITE, !v.rw);
         if (!v.rw) chk("setup_pwdata", PWDATA, v.wdata);
         transfer = 1'b0;
         drive_slaves(0, 1'b0, 1'b0, 8'h00);
         for (int j = 0; j <= v.waits; j++) begin
            @(negedge PCLK);
            chk_common();
            chk("access_psel", {PSEL2, PSEL1}, v.exp_sel);
            chk("access_penable", PENABLE, 1'b1);
            chk("access_busy", busy, 1'b1);
            chk("access_paddr", PADDR, v.addr);
            if (!v.rw) chk("access_pwdata", PWDATA, v.wdata);
            drive_slaves(sel, j == v.waits, v.slverr, v.rdata);
            if (j == v.waits) begin
               pend_done = 1'b1;
               pend_err  = v.exp_err;
               if (v.rw) exp_rd = v.rdata;
               if (v.b2b && (i + 1 < n)) present(vecs[i + 1]);
            end
         end
         if (!(v.b2b && (i + 1 < n))) begin
            @(negedge PCLK);
            chk_common();
            chk("idle_psel", {PSEL2, PSEL1}, 2'b00);
            chk("idle_penable", PENABLE, 1'b0);
            chk("idle_busy", busy, 1'b0);
            drive_slaves(0, 1'b0, 1'b0, 8'h00);
            if (i + 1 < n) present(vecs[i + 1]);
         end
      end
      @(negedge PCLK);
      chk_common();
      $display("sequence of %0d transfers complete, checks=%0d errors=%0d", n, checks, errors);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge PCLK);
      chk_all_zero("reset");
      PRESETn = 1'b1;

      // Directed table
      vecs.push_back(mk(0, 8'h12, 8'hA5, 0, 0, 8'h00, 0, 2'b01, 0));
      vecs.push_back(mk(1, 8'h85, 8'h00, 2, 0, 8'h3C, 0, 2'b10, 0));
      vecs.push_back(mk(0, 8'h10, 8'h55, 0, 0, 8'h00, 1, 2'b01, 0));
      vecs.push_back(mk(1, 8'h90, 8'h00, 0, 0, 8'hC3, 0, 2'b10, 0));
      vecs.push_back(mk(0, 8'h20, 8'h5A, 0, 1, 8'h00, 0, 2'b01, 1));
      vecs.push_back(mk(1, 8'h21, 8'h00, 1, 0, 8'h77, 0, 2'b01, 0));
      vecs.push_back(mk(1, 8'hA0, 8'h00, 0, 1, 8'h99, 1, 2'b10, 1));
      vecs.push_back(mk(0, 8'h7F, 8'h01, 1, 0, 8'h00, 1, 2'b01, 0));
      vecs.push_back(mk(0, 8'h80, 8'hFE, 0, 0, 8'h00, 0, 2'b10, 0));
      run_seq();

      // Randomized transfers; reference: slave 2 iff address >= 128
      vecs.delete();
      for (int k = 0; k < 24; k++) begin
         logic [7:0] a;
         bit         e;
         a = 8'($urandom);
         e = 1'($urandom_range(0, 3) == 0);
         vecs.push_back(mk(1'($urandom), a, 8'($urandom), $urandom_range(0, 3), e,
                           8'($urandom), (k < 23) ? 1'($urandom) : 1'b0,
                           (a >= 8'd128) ? 2'b10 : 2'b01, e));
      end
      run_seq();

      // Reset asserted in the middle of an ACCESS wait
      @(negedge PCLK);
      present(mk(0, 8'h44, 8'h33, 5, 0, 8'h00, 0, 2'b01, 0));
      @(negedge PCLK);
      transfer = 1'b0;
      drive_slaves(1, 1'b0, 1'b0, 8'h00);
      @(negedge PCLK);
      chk("pre_reset_penable", PENABLE, 1'b1);
      drive_slaves(1, 1'b0, 1'b0, 8'h00);
      #2 PRESETn = 1'b0;
      #1 chk_all_zero("mid_access_reset");
      @(negedge PCLK);
      chk("reset_no_done", done, 1'b0);
      PRESETn   = 1'b1;
      exp_rd    = '0;
      pend_done = 1'b0;
      @(negedge PCLK);
      chk("after_reset_done", done, 1'b0);
      chk("after_reset_busy", busy, 1'b0);
      vecs.delete();
      vecs.push_back(mk(1, 8'h05, 8'h00, 1, 0, 8'h6E, 0, 2'b01, 0));
      run_seq();

`ifdef APB_TIMEOUT_EN
      begin
         int acc;
         bit fin;
         acc = 0;
         fin = 1'b0;
         @(negedge PCLK);
         present(mk(1, 8'h06, 8'h00, 0, 0, 8'h00, 0, 2'b01, 0));
         PREADY1 = 1'b0;
         @(negedge PCLK);
         transfer = 1'b0;
         for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge PCLK);
            if (PENABLE) begin
               acc++;
               PREADY1 = 1'b0; PREADY2 = 1'b1; PRDATA1 = 8'hEE;
            end else begin
               fin = 1'b1;
            end
         end
         chk("timeout_reached", fin, 1'b1);
         chk("timeout_wait_cycles", acc, 16);
         chk("timeout_done", done, 1'b1);
         chk("timeout_error", error, 1'b1);
         chk("timeout_psel", {PSEL2, PSEL1}, 2'b00);
         chk("timeout_busy", busy, 1'b0);
         chk("timeout_rdata", apb_read_data_out, exp_rd);
         @(negedge PCLK);
         chk("timeout_done_pulse", done, 1'b0);
         $display("timeout transfer: %0d wait cycles", acc);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
